// File: rtl/rs_alu_pkg.sv
// Shared types for the ALU reservation station: renamed op payload, RS entry and ROB-window helper.
package rs_alu_pkg;

  localparam int unsigned RobSize = 16;
  localparam int unsigned RobTagW = 5;
  localparam int unsigned RobIdxW = $clog2(RobSize);
  localparam int unsigned PregW   = 7;

  typedef enum logic [6:0] {
    OpImm = 7'b0010011,
    OpLui = 7'b0110111,
    OpReg = 7'b0110011
  } alu_opcode_e;

  typedef struct packed {
    logic [PregW-1:0]   pd;
    logic [PregW-1:0]   ps1;
    logic [PregW-1:0]   ps2;
    logic [RobTagW-1:0] rob_index;
    logic [6:0]         opcode;
    logic [2:0]         func3;
    logic [6:0]         func7;
    logic [31:0]        imm;
  } rs_data_t;

  typedef struct packed {
    logic     valid;
    logic     rdy1;
    logic     rdy2;
    rs_data_t data;
  } rs_entry_t;

  // Tags strictly younger than mp_tag and older than tail; mp_tag+1 == tail is an empty window.
  function automatic logic in_flush_window(input logic [RobIdxW-1:0] tag,
                                           input logic [RobIdxW-1:0] mp_tag,
                                           input logic [RobIdxW-1:0] tail);
    logic [RobIdxW-1:0] off;
    logic [RobIdxW-1:0] len;
    off = tag - mp_tag - 1'b1;
    len = tail - mp_tag - 1'b1;
    return off < len;
  endfunction

endpackage

// File: rtl/rs_pri_enc.sv
// Lowest-index-first priority encoder over a Depth-wide request vector.
module rs_pri_enc #(
  parameter int unsigned Depth = 8,
  localparam int unsigned IdxW = $clog2(Depth)
) (
  input  logic [Depth-1:0] req_i,
  output logic [IdxW-1:0]  idx_o,
  output logic             valid_o
);

  always_comb begin
    idx_o   = '0;
    valid_o = 1'b0;
    // Scanning downward leaves the lowest set index as the final winner.
    for (int i = Depth - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        idx_o   = IdxW'(i);
        valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rs_alu.sv
// Reservation station for the integer ALU pipe: buffers renamed ops, snoops CDB wakeups,
// issues one ready op per cycle and squashes ops younger than a mispredicted branch.
module rs_alu
  import rs_alu_pkg::*;
#(
  parameter int unsigned Depth = 8,
  parameter int unsigned NWake = 3
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     disp_valid_i,
  input  rs_data_t                 disp_data_i,
  input  logic                     disp_ps1_rdy_i,
  input  logic                     disp_ps2_rdy_i,
  output logic                     rs_full_o,
  input  logic [NWake-1:0]         wake_valid_i,
  input  logic [NWake*PregW-1:0]   wake_tag_i,
  input  logic                     fu_alu_ready_i,
  output logic                     issued_o,
  output rs_data_t                 data_out_o,
  input  logic [RobTagW-1:0]       curr_rob_tag_i,
  input  logic                     mispredict_i,
  input  logic [RobTagW-1:0]       mispredict_tag_i
);

  localparam int unsigned IdxW = $clog2(Depth);

  rs_entry_t [Depth-1:0] ent_q, ent_d;
  logic                  issued_q, issued_d;
  rs_data_t              data_out_q, data_out_d;

  logic [Depth-1:0] free_vec, ready_vec;
  logic [IdxW-1:0]  free_idx, sel_idx;
  logic             free_vld, sel_vld;

  // ROB tags wrap at RobSize, so only the low bits take part in window math.
  logic unused_tag_msb;
  assign unused_tag_msb = ^{curr_rob_tag_i[RobTagW-1:RobIdxW],
                            mispredict_tag_i[RobTagW-1:RobIdxW]};

  function automatic logic wake_hit(input logic [PregW-1:0]       tag,
                                    input logic [NWake-1:0]       vld,
                                    input logic [NWake*PregW-1:0] tags);
    logic hit;
    hit = (tag == '0);
    for (int k = 0; k < NWake; k++) begin
      if (vld[k] && (tags[k*PregW +: PregW] == tag)) hit = 1'b1;
    end
    return hit;
  endfunction

  function automatic logic flushed(input logic [RobTagW-1:0] rob, input logic mp,
                                   input logic [RobTagW-1:0] mp_tag,
                                   input logic [RobTagW-1:0] tail);
    return mp && in_flush_window(rob[RobIdxW-1:0], mp_tag[RobIdxW-1:0], tail[RobIdxW-1:0]);
  endfunction

  always_comb begin
    for (int i = 0; i < Depth; i++) begin
      free_vec[i]  = ~ent_q[i].valid;
      ready_vec[i] = ent_q[i].valid & ent_q[i].rdy1 & ent_q[i].rdy2;
    end
  end

  rs_pri_enc #(.Depth(Depth)) u_free_enc (
    .req_i   (free_vec),
    .idx_o   (free_idx),
    .valid_o (free_vld)
  );

  rs_pri_enc #(.Depth(Depth)) u_sel_enc (
    .req_i   (ready_vec),
    .idx_o   (sel_idx),
    .valid_o (sel_vld)
  );

  assign rs_full_o  = ~free_vld;
  assign issued_o   = issued_q;
  assign data_out_o = data_out_q;

  always_comb begin
    ent_d      = ent_q;
    issued_d   = 1'b0;
    data_out_d = data_out_q;

    if (fu_alu_ready_i && sel_vld) begin
      ent_d[sel_idx].valid = 1'b0;
      if (flushed(ent_q[sel_idx].data.rob_index, mispredict_i, mispredict_tag_i,
                  curr_rob_tag_i)) begin
        data_out_d = '0;
      end else begin
        issued_d   = 1'b1;
        data_out_d = ent_q[sel_idx].data;
      end
    end

    for (int i = 0; i < Depth; i++) begin
      if (wake_hit(ent_q[i].data.ps1, wake_valid_i, wake_tag_i)) ent_d[i].rdy1 = 1'b1;
      if (wake_hit(ent_q[i].data.ps2, wake_valid_i, wake_tag_i)) ent_d[i].rdy2 = 1'b1;
      if (flushed(ent_q[i].data.rob_index, mispredict_i, mispredict_tag_i, curr_rob_tag_i)) begin
        ent_d[i].valid = 1'b0;
      end
    end

    // The free slot comes from registered state, so it never collides with this cycle's select.
    if (disp_valid_i && free_vld &&
        !flushed(disp_data_i.rob_index, mispredict_i, mispredict_tag_i, curr_rob_tag_i)) begin
      ent_d[free_idx].valid = 1'b1;
      ent_d[free_idx].rdy1  = disp_ps1_rdy_i | wake_hit(disp_data_i.ps1, wake_valid_i, wake_tag_i);
      ent_d[free_idx].rdy2  = disp_ps2_rdy_i | wake_hit(disp_data_i.ps2, wake_valid_i, wake_tag_i);
      ent_d[free_idx].data  = disp_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      ent_q      <= '0;
      issued_q   <= 1'b0;
      data_out_q <= '0;
    end else begin
      ent_q      <= ent_d;
      issued_q   <= issued_d;
      data_out_q <= data_out_d;
    end
  end

endmodule
